cache_line_refill_engine: RTL

- Sits between the cache controller and the byte-wide main memory.
- Takes one line-miss request from the cache: a line fill plus an optional dirty-victim writeback.
- Sequences the victim out as 8 byte writes, then the fill in as 8 byte reads.
- Returns the assembled 64-bit line to the cache through a valid/ready handshake.

---
 rtl/cache_line_refill_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cache_line_refill_engine.sv
// Line refill engine: accepts one miss request, optionally writes the dirty
// victim out as byte writes, then reads the fill line byte by byte and hands
// the assembled line back to the cache over a valid/ready handshake.
module cache_line_refill_engine #(
    parameter int LINE_BYTES = 8,
    parameter int READ_WAIT  = 0,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_fill_addr,
    input  logic              req_wb,
    input  logic [31:0]       req_wb_addr,
    input  logic [63:0]       req_wb_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic [31:0]       resp_addr,
    output logic [31:0]       mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic [STAT_W-1:0] stat_fills,
    output logic [STAT_W-1:0] stat_wbs
);

    localparam int BEAT_W = $clog2(LINE_BYTES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES - 1);
    localparam logic [3:0]        WAIT_LAST = 4'(READ_WAIT);

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t               state, state_n;
    logic [BEAT_W-1:0]    beat, beat_n;
    logic [3:0]           wait_cnt, wait_n;
    logic [31-BEAT_W:0]   fill_addr, fill_addr_n;
    logic [31-BEAT_W:0]   wb_addr, wb_addr_n;
    logic [63:0]          wb_data, wb_data_n;
    logic [63:0]          line, line_n;
    logic                 req_ready_n, resp_valid_n, mem_we_n;
    logic [63:0]          resp_data_n;
    logic [31:0]          resp_addr_n, mem_addr_n;
    logic [7:0]           mem_wdata_n;
    logic [STAT_W-1:0]    stat_fills_n, stat_wbs_n;

    // Byte-offset bits of the request addresses are intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{req_fill_addr[BEAT_W-1:0], req_wb_addr[BEAT_W-1:0]};

    // Next-state and next-output logic; every output is a register, so the
    // address/data for the first beat of a phase is prepared on the edge
    // that enters that phase.
    always_comb begin
        state_n      = state;
        beat_n       = beat;
        wait_n       = wait_cnt;
        fill_addr_n  = fill_addr;
        wb_addr_n    = wb_addr;
        wb_data_n    = wb_data;
        line_n       = line;
        req_ready_n  = req_ready;
        resp_valid_n = resp_valid;
        resp_data_n  = resp_data;
        resp_addr_n  = resp_addr;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_we_n     = 1'b0;
        stat_fills_n = stat_fills;
        stat_wbs_n   = stat_wbs;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    fill_addr_n = req_fill_addr[31:BEAT_W];
                    wb_addr_n   = req_wb_addr[31:BEAT_W];
                    wb_data_n   = req_wb_data;
                    beat_n      = '0;
                    wait_n      = '0;
                    req_ready_n = 1'b0;
                    if (req_wb) begin
                        state_n     = WB;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = {req_wb_addr[31:BEAT_W], {BEAT_W{1'b0}}};
                        mem_wdata_n = req_wb_data[7:0];
                    end else begin
                        state_n    = FILL;
                        mem_addr_n = {req_fill_addr[31:BEAT_W], {BEAT_W{1'b0}}};
                    end
                end
            end
            WB: begin
                if (beat == LAST_BEAT) begin
                    stat_wbs_n = stat_wbs + STAT_W'(1);
                    beat_n     = '0;
                    state_n    = FILL;
                    mem_addr_n = {fill_addr, {BEAT_W{1'b0}}};
                end else begin
                    beat_n      = beat + BEAT_W'(1);
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {wb_addr, beat_n};
                    mem_wdata_n = wb_data[{beat_n, 3'b000} +: 8];
                end
            end
            FILL: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_n = '0;
                    line_n[{beat, 3'b000} +: 8] = mem_rdata;
                    if (beat == LAST_BEAT) begin
                        stat_fills_n = stat_fills + STAT_W'(1);
                        beat_n       = '0;
                        resp_data_n  = line_n;
                        resp_addr_n  = {fill_addr, {BEAT_W{1'b0}}};
                        resp_valid_n = 1'b1;
                        state_n      = RESP;
                    end else begin
                        beat_n     = beat + BEAT_W'(1);
                        mem_addr_n = {fill_addr, beat_n};
                    end
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    req_ready_n  = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            wait_cnt   <= '0;
            fill_addr  <= '0;
            wb_addr    <= '0;
            wb_data    <= '0;
            line       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_addr  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            stat_fills <= '0;
            stat_wbs   <= '0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            wait_cnt   <= wait_n;
            fill_addr  <= fill_addr_n;
            wb_addr    <= wb_addr_n;
            wb_data    <= wb_data_n;
            line       <= line_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_data  <= resp_data_n;
            resp_addr  <= resp_addr_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_we     <= mem_we_n;
            stat_fills <= stat_fills_n;
            stat_wbs   <= stat_wbs_n;
        end
    end

endmodule
